bus_arbiter_2x1: RTL and testbench

BUS_ARBITER_2X1 -- requirements
Module: bus_arbiter_2x1

---
 rtl/bus_if_types_pkg.sv | 30 +++
 rtl/master_bus_if.sv | 23 ++
 rtl/arb_pick2.sv | 38 +++
 rtl/bus_arbiter_2x1.sv | 125 ++++++++++++
 tb/tb_bus_arbiter_2x1.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_if_types_pkg.sv
// Shared bus transfer types and the arbiter state encoding.
// The arbiter state values double as the one-hot grant vector.
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } tsize_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_M0 = 2'b01,
    OWN_M1 = 2'b10
  } arb_state_e;

  function automatic arb_state_e pick_to_state(input logic [1:0] pick);
    case (pick)
      2'b01:   return OWN_M0;
      2'b10:   return OWN_M1;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/master_bus_if.sv
// Simple core bus: requester drives the transfer, the far side answers with bdone/rdata.
interface master_bus_if;
  import bus_if_types_pkg::*;

  logic        bstart;
  logic        breq;
  ttype_e      ttype;
  tsize_e      tsize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;

  modport slave (
    input  bstart, breq, ttype, tsize, addr, wdata,
    output rdata, bdone
  );

  modport master (
    output bstart, breq, ttype, tsize, addr, wdata,
    input  rdata, bdone
  );
endinterface

// File: rtl/arb_pick2.sv
// Two-way request picker: fixed priority (m0 first) by default,
// round-robin between m0 and m1 when ARB_ROUND_ROBIN_EN is defined.
module arb_pick2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] pick
);
`ifdef ARB_ROUND_ROBIN_EN
  logic prio_m1_reg;  // set when m1 should win the next tie

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_m1_reg <= 1'b0;
    end else if (take) begin
      prio_m1_reg <= pick[0];
    end
  end

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = prio_m1_reg ? 2'b10 : 2'b01;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = clk ^ rst_n ^ take;

  always_comb begin
    pick = req;
    if (req[0]) begin
      pick = 2'b01;
    end
  end
`endif
endmodule

// File: rtl/bus_arbiter_2x1.sv
// 2:1 bus arbiter (m0 = dbus, m1 = ibus) onto one shared slave port with transfer timeout.
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking instead of fixed m0 priority.
module bus_arbiter_2x1
  import bus_if_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  master_bus_if.slave  m0,
  master_bus_if.slave  m1,
  master_bus_if.master s,
  output logic [1:0]   grant,
  output logic         timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             arm_reg;
  logic [1:0]       req, pick;
  logic             pick_take, own_m0, own_m1, timeout_hit;

  assign req         = {m1.breq, m0.breq};
  assign own_m0      = (state_reg == OWN_M0);
  assign own_m1      = (state_reg == OWN_M1);
  assign grant       = state_reg;
  assign timeout_err = timeout_hit;

  arb_pick2 u_pick (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .take (pick_take),
    .pick (pick)
  );

  // A real completion on the limit cycle takes precedence over the abort.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign timeout_hit = (own_m0 | own_m1) & ~s.bdone & (cnt_reg == CNT_LIMIT);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // arm_reg holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      arm_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      arm_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pick_take  = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (arm_reg && (|req)) begin
          pick_take  = 1'b1;
          state_next = pick_to_state(pick);
        end
      end
      OWN_M0, OWN_M1: begin
        if (s.bdone) begin
          pick_take  = |req;
          state_next = pick_to_state(pick);
          cnt_next   = '0;
        end else if (timeout_hit) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    s.bstart = 1'b0;
    s.breq   = 1'b0;
    s.ttype  = READ;
    s.tsize  = WORD;
    s.addr   = '0;
    s.wdata  = '0;
    m0.bdone = 1'b0;
    m0.rdata = '0;
    m1.bdone = 1'b0;
    m1.rdata = '0;
    if (own_m0) begin
      s.bstart = m0.bstart & ~timeout_hit;
      s.breq   = m0.breq & ~timeout_hit;
      s.ttype  = m0.ttype;
      s.tsize  = m0.tsize;
      s.addr   = m0.addr;
      s.wdata  = m0.wdata;
      m0.bdone = s.bdone | timeout_hit;
      m0.rdata = timeout_hit ? 32'h0 : s.rdata;
    end else if (own_m1) begin
      s.bstart = m1.bstart & ~timeout_hit;
      s.breq   = m1.breq & ~timeout_hit;
      s.ttype  = m1.ttype;
      s.tsize  = m1.tsize;
      s.addr   = m1.addr;
      s.wdata  = m1.wdata;
      m1.bdone = s.bdone | timeout_hit;
      m1.rdata = timeout_hit ? 32'h0 : s.rdata;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2x1.sv
// Self-checking bench for bus_arbiter_2x1: directed scenarios plus a randomized run
// against a behavioural owner/wait-count model (honours ARB_ROUND_ROBIN_EN).
module tb_bus_arbiter_2x1;
  import bus_if_types_pkg::*;

  localparam int TMO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant;
  logic       timeout_err;
  int         checks = 0;
  int         failures = 0;

  // model: owner 0 = none, 1 = m0, 2 = m1
  int mo_owner;
  int mo_wait;
  bit mo_prio_m1;

  master_bus_if m0_if ();
  master_bus_if m1_if ();
  master_bus_if s_if ();

  bus_arbiter_2x1 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    m0_if.bstart = 1'b0; m0_if.breq = 1'b0; m0_if.ttype = READ; m0_if.tsize = WORD;
    m0_if.addr = 32'h0; m0_if.wdata = 32'h0;
    m1_if.bstart = 1'b0; m1_if.breq = 1'b0; m1_if.ttype = READ; m1_if.tsize = WORD;
    m1_if.addr = 32'h0; m1_if.wdata = 32'h0;
    s_if.rdata = 32'h0; s_if.bdone = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic int mdl_pick(logic r0, logic r1);
    if (r0 && r1) return (RR && mo_prio_m1) ? 2 : 1;
    if (r0) return 1;
    if (r1) return 2;
    return 0;
  endfunction

  function automatic logic mdl_timeout();
    return (TMO > 0) && (mo_owner != 0) && !s_if.bdone && (mo_wait >= TMO);
  endfunction

  function automatic logic [137:0] mdl_expect();
    logic tmo, sb, sr, d0, d1;
    ttype_e tt;
    tsize_e ts;
    logic [31:0] sa, sw, r0, r1;
    logic [1:0] g;
    tmo = mdl_timeout();
    sb = 1'b0; sr = 1'b0; tt = READ; ts = WORD; sa = 32'h0; sw = 32'h0;
    d0 = 1'b0; d1 = 1'b0; r0 = 32'h0; r1 = 32'h0; g = 2'b00;
    if (mo_owner == 1) begin
      g = 2'b01; sb = m0_if.bstart; sr = m0_if.breq; tt = m0_if.ttype; ts = m0_if.tsize;
      sa = m0_if.addr; sw = m0_if.wdata;
      d0 = s_if.bdone | tmo; r0 = tmo ? 32'h0 : s_if.rdata;
    end else if (mo_owner == 2) begin
      g = 2'b10; sb = m1_if.bstart; sr = m1_if.breq; tt = m1_if.ttype; ts = m1_if.tsize;
      sa = m1_if.addr; sw = m1_if.wdata;
      d1 = s_if.bdone | tmo; r1 = tmo ? 32'h0 : s_if.rdata;
    end
    return {g, sb & ~tmo, sr & ~tmo, tt, ts, sa, sw, d0, r0, d1, r1, tmo};
  endfunction

  task automatic mdl_advance();
    int nxt;
    logic tmo;
    tmo = mdl_timeout();
    if (mo_owner == 0 || s_if.bdone) nxt = mdl_pick(m0_if.breq, m1_if.breq);
    else if (tmo) nxt = 0;
    else nxt = mo_owner;
    if (mo_owner != 0 && !s_if.bdone && !tmo) mo_wait++;
    else mo_wait = 0;
    if ((mo_owner == 0 || s_if.bdone) && nxt != 0) mo_prio_m1 = (nxt == 1);
    mo_owner = nxt;
  endtask

  task automatic test_reset();
    logic [2:0] idle_tt;
    idle_tt = {READ, WORD};
    rst_n = 1'b0;
    drive_idle();
    m0_if.breq = 1'b1; m0_if.bstart = 1'b1; m0_if.addr = 32'hA5A5_0000; m0_if.wdata = 32'h1;
    s_if.bdone = 1'b1;
    tick();
    checks++; if ({grant, timeout_err} !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b want=000", {grant, timeout_err}); end
    checks++; if ({s_if.bstart, s_if.breq, s_if.addr, s_if.wdata} !== 66'd0) begin failures++; $display("FAIL reset_s_idle got=%h want=0", {s_if.bstart, s_if.breq, s_if.addr, s_if.wdata}); end
    checks++; if ({s_if.ttype, s_if.tsize} !== idle_tt) begin failures++; $display("FAIL reset_s_type got=%b want=%b", {s_if.ttype, s_if.tsize}, idle_tt); end
    checks++; if ({m0_if.bdone, m1_if.bdone} !== 2'b00) begin failures++; $display("FAIL reset_bdone got=%b want=00", {m0_if.bdone, m1_if.bdone}); end
    tick();
    rst_n = 1'b1;
    s_if.bdone = 1'b0;
    mid();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_release_grant got=%b want=00", grant); end
    tick();
    mid();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_first_edge_grant got=%b want=00", grant); end
    tick();
    mid();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL reset_second_edge_grant got=%b want=01", grant); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    m1_if.breq = 1'b1; m1_if.bstart = 1'b1; m1_if.addr = 32'h0000_0100; m1_if.ttype = READ;
    mid();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL single_arb_latency got=%b want=00", grant); end
    tick();
    mid();
    checks++; if ({grant, s_if.bstart, s_if.addr} !== {2'b10, 1'b1, 32'h0000_0100}) begin failures++; $display("FAIL single_grant got=%h want=%h", {grant, s_if.bstart, s_if.addr}, {2'b10, 1'b1, 32'h0000_0100}); end
    m1_if.bstart = 1'b0;
    tick();
    mid();
    checks++; if ({m0_if.bdone, m1_if.bdone, grant} !== 4'b0010) begin failures++; $display("FAIL single_wait got=%b want=0010", {m0_if.bdone, m1_if.bdone, grant}); end
    tick();
    s_if.bdone = 1'b1; s_if.rdata = 32'hDEAD_BEEF; m1_if.breq = 1'b0;
    mid();
    checks++; if ({m1_if.bdone, m1_if.rdata} !== {1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL single_m1_done got=%h want=%h", {m1_if.bdone, m1_if.rdata}, {1'b1, 32'hDEAD_BEEF}); end
    checks++; if ({m0_if.bdone, m0_if.rdata} !== 33'd0) begin failures++; $display("FAIL single_m0_quiet got=%h want=0", {m0_if.bdone, m0_if.rdata}); end
    tick();
    s_if.bdone = 1'b0;
    mid();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL single_back_idle got=%b want=00", grant); end
    $display("test_single done");
  endtask

  task automatic test_contention();
    do_reset();
    m0_if.breq = 1'b1; m0_if.bstart = 1'b1; m0_if.addr = 32'h0000_0A00;
    m1_if.breq = 1'b1; m1_if.bstart = 1'b1; m1_if.addr = 32'h0000_0B00;
    tick();
    s_if.bdone = 1'b1; m0_if.breq = 1'b0;
    mid();
    checks++; if ({grant, s_if.bstart, s_if.addr, m0_if.bdone} !== {2'b01, 1'b1, 32'h0000_0A00, 1'b1}) begin failures++; $display("FAIL contention_m0_first got=%h want=%h", {grant, s_if.bstart, s_if.addr, m0_if.bdone}, {2'b01, 1'b1, 32'h0000_0A00, 1'b1}); end
    tick();
    m0_if.bstart = 1'b0; m1_if.breq = 1'b0;
    mid();
    checks++; if ({grant, s_if.bstart, s_if.addr, m1_if.bdone} !== {2'b10, 1'b1, 32'h0000_0B00, 1'b1}) begin failures++; $display("FAIL contention_m1_no_bubble got=%h want=%h", {grant, s_if.bstart, s_if.addr, m1_if.bdone}, {2'b10, 1'b1, 32'h0000_0B00, 1'b1}); end
    tick();
    s_if.bdone = 1'b0; m1_if.bstart = 1'b0;
    mid();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL contention_idle got=%b want=00", grant); end
    $display("test_contention done");
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    do_reset();
    m0_if.breq = 1'b1; m1_if.breq = 1'b1; s_if.bdone = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      want = (RR && (r % 2 == 1)) ? 2'b10 : 2'b01;
      mid();
      checks++; if (grant !== want) begin failures++; $display("FAIL back_to_back_round%0d got=%b want=%b", r, grant, want); end
      tick();
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_release();
    do_reset();
    m0_if.breq = 1'b1; m0_if.bstart = 1'b1; m0_if.addr = 32'h0000_0040;
    tick();
    m0_if.breq = 1'b0; m0_if.bstart = 1'b0; m1_if.breq = 1'b1; m1_if.bstart = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL release_hold cyc%0d got=%b want=01", i, grant); end
      tick();
    end
    s_if.bdone = 1'b1;
    mid();
    checks++; if ({m0_if.bdone, m1_if.bdone} !== 2'b10) begin failures++; $display("FAIL release_done got=%b want=10", {m0_if.bdone, m1_if.bdone}); end
    tick();
    s_if.bdone = 1'b0;
    mid();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL release_next_m1 got=%b want=10", grant); end
    $display("test_release done");
  endtask

  task automatic test_timeout();
    do_reset();
    m0_if.breq = 1'b1; m0_if.bstart = 1'b1; m0_if.ttype = WRITE;
    m0_if.addr = 32'h0000_2000; m0_if.wdata = 32'h1234_5678;
    m1_if.breq = 1'b1; m1_if.bstart = 1'b1; m1_if.addr = 32'h0000_3000;
    s_if.rdata = 32'hFFFF_FFFF;
    tick();
    m0_if.bstart = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      mid();
      checks++; if ({grant, m0_if.bdone, timeout_err, s_if.breq, s_if.ttype, s_if.wdata} !== {2'b01, 1'b0, 1'b0, 1'b1, WRITE, 32'h1234_5678}) begin failures++; $display("FAIL timeout_wait cyc%0d got=%h want=%h", i, {grant, m0_if.bdone, timeout_err, s_if.breq, s_if.ttype, s_if.wdata}, {2'b01, 1'b0, 1'b0, 1'b1, WRITE, 32'h1234_5678}); end
      tick();
    end
    mid();
    checks++; if ({m0_if.bdone, m0_if.rdata, timeout_err} !== {1'b1, 32'h0, 1'b1}) begin failures++; $display("FAIL timeout_abort got=%h want=%h", {m0_if.bdone, m0_if.rdata, timeout_err}, {1'b1, 32'h0, 1'b1}); end
    checks++; if ({s_if.bstart, s_if.breq, m1_if.bdone} !== 3'b000) begin failures++; $display("FAIL timeout_drop_s got=%b want=000", {s_if.bstart, s_if.breq, m1_if.bdone}); end
    tick();
    m0_if.breq = 1'b0;
    mid();
    checks++; if ({grant, timeout_err} !== 3'b000) begin failures++; $display("FAIL timeout_idle got=%b want=000", {grant, timeout_err}); end
    tick();
    mid();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL timeout_m1_next got=%b want=10", grant); end
    m1_if.bstart = 1'b0;
    for (int i = 0; i < TMO; i++) tick();
    s_if.bdone = 1'b1; s_if.rdata = 32'hCAFE_F00D; m1_if.breq = 1'b0;
    mid();
    checks++; if ({m1_if.bdone, m1_if.rdata, timeout_err} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin failures++; $display("FAIL timeout_bdone_wins got=%h want=%h", {m1_if.bdone, m1_if.rdata, timeout_err}, {1'b1, 32'hCAFE_F00D, 1'b0}); end
    tick();
    s_if.bdone = 1'b0;
    mid();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL timeout_final_idle got=%b want=00", grant); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_if.breq = 1'b1; m1_if.bstart = 1'b1; m1_if.addr = 32'h0000_0080;
    tick();
    mid();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL reset_mid_owned got=%b want=10", grant); end
    tick();
    s_if.bdone = 1'b1; s_if.rdata = 32'h0000_0055;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({grant, s_if.bstart, s_if.breq} !== 4'b0000) begin failures++; $display("FAIL reset_mid_s got=%b want=0000", {grant, s_if.bstart, s_if.breq}); end
    checks++; if ({m0_if.bdone, m1_if.bdone, m1_if.rdata} !== 34'd0) begin failures++; $display("FAIL reset_mid_bdone got=%h want=0", {m0_if.bdone, m1_if.bdone, m1_if.rdata}); end
    drive_idle();
    tick();
    rst_n = 1'b1;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [137:0] obs, expv;
    int start_fail;
    start_fail = failures;
    do_reset();
    mo_owner = 0; mo_wait = 0; mo_prio_m1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      m0_if.breq = ($urandom_range(0, 99) < 60); m0_if.bstart = $urandom_range(0, 1) == 1;
      m0_if.ttype = ttype_e'($urandom_range(0, 1)); m0_if.tsize = tsize_e'($urandom_range(0, 2));
      m0_if.addr = $urandom; m0_if.wdata = $urandom;
      m1_if.breq = ($urandom_range(0, 99) < 60); m1_if.bstart = $urandom_range(0, 1) == 1;
      m1_if.ttype = ttype_e'($urandom_range(0, 1)); m1_if.tsize = tsize_e'($urandom_range(0, 2));
      m1_if.addr = $urandom; m1_if.wdata = $urandom;
      s_if.bdone = ($urandom_range(0, 3) == 0); s_if.rdata = $urandom;
      mid();
      expv = mdl_expect();
      obs = {grant, s_if.bstart, s_if.breq, s_if.ttype, s_if.tsize, s_if.addr, s_if.wdata,
             m0_if.bdone, m0_if.rdata, m1_if.bdone, m1_if.rdata, timeout_err};
      checks++; if (obs !== expv) begin failures++; $display("FAIL random cyc%0d got=%h want=%h", c, obs, expv); end
      mdl_advance();
      tick();
    end
    $display("test_random done: %0d cycles, %0d new failures", 3000, failures - start_fail);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_release();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
